// File: rtl/steer_pkg.sv
// Shared types and helpers for the 3-way NCL steer scheduler.
// Holds the FSM state enum, destination index codes, the one-hot steer
// constants and small index helpers used by the arbiter and the scheduler.
package steer_pkg;

    localparam int unsigned IDX_W = 2;
    localparam int unsigned SEL_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        NULLW = 2'd2
    } state_t;

    // Destination indices; IDX_NONE marks "no current owner".
    localparam logic [IDX_W-1:0] IDX_S    = 2'd0;
    localparam logic [IDX_W-1:0] IDX_T    = 2'd1;
    localparam logic [IDX_W-1:0] IDX_U    = 2'd2;
    localparam logic [IDX_W-1:0] IDX_NONE = 2'd3;

    localparam logic [SEL_W-1:0] SEL_NULL = 3'b000;
    localparam logic [SEL_W-1:0] SEL_S    = 3'b001;
    localparam logic [SEL_W-1:0] SEL_T    = 3'b010;
    localparam logic [SEL_W-1:0] SEL_U    = 3'b100;

    // Destination index to steer rail; anything else is NULL.
    function automatic logic [SEL_W-1:0] onehot3(input logic [IDX_W-1:0] idx);
        case (idx)
            IDX_S:   return SEL_S;
            IDX_T:   return SEL_T;
            IDX_U:   return SEL_U;
            default: return SEL_NULL;
        endcase
    endfunction

    // Circular successor S->T->U->S.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx >= IDX_U) ? IDX_S : idx + IDX_W'(1);
    endfunction

endpackage

// File: rtl/steer_rr_arb3.sv
// Combinational 3-way arbiter for the steer scheduler.
// Ports:
//   req       : destination requests (bit0=S, bit1=T, bit2=U)
//   mode      : 0 = round-robin with burst quantum, 1 = fixed priority S>T>U
//   rr_ptr    : round-robin search start index
//   owner     : destination holding the burst, IDX_NONE if none
//   burst_cnt : tokens already granted to owner
//   winner_c  : winning destination index
//   valid_c   : at least one request present
module steer_rr_arb3
    import steer_pkg::*;
#(
    parameter int unsigned BURST = 4,
    parameter int unsigned BC_W  = 4
) (
    input  logic [SEL_W-1:0] req,
    input  logic             mode,
    input  logic [IDX_W-1:0] rr_ptr,
    input  logic [IDX_W-1:0] owner,
    input  logic [BC_W-1:0]  burst_cnt,
    output logic [IDX_W-1:0] winner_c,
    output logic             valid_c
);

    // Padded so any 2-bit index (including IDX_NONE) selects a defined bit.
    logic [3:0]       req_x;
    logic [IDX_W-1:0] cand0;
    logic [IDX_W-1:0] cand1;
    logic [IDX_W-1:0] cand2;
    logic             keep_owner;

    assign req_x = {1'b0, req};
    assign cand0 = rr_ptr;
    assign cand1 = next_idx(cand0);
    assign cand2 = next_idx(cand1);

    // Owner keeps the grant while it still requests and its quantum is not used up.
    assign keep_owner = (owner != IDX_NONE) && req_x[owner] && (burst_cnt < BC_W'(BURST));

    // Winner selection.
    always_comb begin
        winner_c = IDX_S;
        valid_c  = |req;
        if (mode) begin
            if (req[0])      winner_c = IDX_S;
            else if (req[1]) winner_c = IDX_T;
            else             winner_c = IDX_U;
        end else if (keep_owner) begin
            winner_c = owner;
        end else begin
            if (req_x[cand0])      winner_c = cand0;
            else if (req_x[cand1]) winner_c = cand1;
            else                   winner_c = cand2;
        end
    end

endmodule

// File: rtl/steer_sched3.sv
// Scheduler issuing the 3-rail one-hot steer token for a 3-way NCL steer
// stage and running its four-phase DATA/NULL handshake.
// Ports:
//   clk, init    : clock and synchronous active-high reset
//   req[2:0]     : destination requests (bit0=S, bit1=T, bit2=U)
//   mode         : 0 = round-robin with burst, 1 = fixed priority (used in IDLE)
//   steer[2:0]   : one-hot steer token, 000 = NULL
//   steer_comp   : stage completion, 1 = DATA consumed, 0 = NULL consumed
//   busy         : FSM not in IDLE
//   tok_cnt      : completed DATA phases, wrapping
//   err_timeout  : sticky handshake stall flag
module steer_sched3
    import steer_pkg::*;
#(
    parameter int unsigned BURST     = 4,
    parameter int unsigned TO_CYCLES = 255,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             init,
    input  logic [SEL_W-1:0] req,
    input  logic             mode,
    output logic [SEL_W-1:0] steer,
    input  logic             steer_comp,
    output logic             busy,
    output logic [CNT_W-1:0] tok_cnt,
    output logic             err_timeout
);

    localparam int unsigned BC_W   = 4;
    localparam int unsigned WAIT_W = 16;

    state_t           state,     state_nxt;
    logic [SEL_W-1:0] steer_nxt;
    logic             busy_nxt;
    logic [CNT_W-1:0] tok_nxt;
    logic             err_nxt;
    logic [IDX_W-1:0] rr_ptr,    rr_nxt;
    logic [IDX_W-1:0] owner,     owner_nxt;
    logic [BC_W-1:0]  burst_cnt, burst_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_nxt;
    logic [WAIT_W-1:0] wait_inc;
    logic [BC_W-1:0]  burst_inc;
    logic [IDX_W-1:0] arb_winner;
    logic             arb_valid;

    steer_rr_arb3 #(
        .BURST (BURST),
        .BC_W  (BC_W)
    ) u_arb (
        .req       (req),
        .mode      (mode),
        .rr_ptr    (rr_ptr),
        .owner     (owner),
        .burst_cnt (burst_cnt),
        .winner_c  (arb_winner),
        .valid_c   (arb_valid)
    );

    // Saturating increments for the stall timer and the burst quantum.
    assign wait_inc  = (wait_cnt >= WAIT_W'(TO_CYCLES)) ? wait_cnt : wait_cnt + WAIT_W'(1);
    assign burst_inc = (burst_cnt >= BC_W'(BURST)) ? burst_cnt : burst_cnt + BC_W'(1);

    // State and output registers.
    always_ff @(posedge clk) begin
        if (init) begin
            state       <= IDLE;
            steer       <= SEL_NULL;
            busy        <= 1'b0;
            tok_cnt     <= '0;
            err_timeout <= 1'b0;
            rr_ptr      <= IDX_S;
            owner       <= IDX_NONE;
            burst_cnt   <= '0;
            wait_cnt    <= '0;
        end else begin
            state       <= state_nxt;
            steer       <= steer_nxt;
            busy        <= busy_nxt;
            tok_cnt     <= tok_nxt;
            err_timeout <= err_nxt;
            rr_ptr      <= rr_nxt;
            owner       <= owner_nxt;
            burst_cnt   <= burst_nxt;
            wait_cnt    <= wait_nxt;
        end
    end

    // Next-state and next-output logic; steer only changes on IDLE->DATA and DATA->NULLW.
    always_comb begin
        state_nxt = state;
        steer_nxt = steer;
        tok_nxt   = tok_cnt;
        err_nxt   = err_timeout;
        rr_nxt    = rr_ptr;
        owner_nxt = owner;
        burst_nxt = burst_cnt;
        wait_nxt  = wait_cnt;

        case (state)
            IDLE: begin
                // A completion still high in IDLE is a stale acknowledge; hold off.
                if (!steer_comp && arb_valid) begin
                    state_nxt = DATA;
                    steer_nxt = onehot3(arb_winner);
                    wait_nxt  = '0;
                    if (!mode && (arb_winner != owner)) begin
                        owner_nxt = arb_winner;
                        burst_nxt = '0;
                        rr_nxt    = next_idx(arb_winner);
                    end
                end
            end
            DATA: begin
                if (steer_comp) begin
                    state_nxt = NULLW;
                    steer_nxt = SEL_NULL;
                    tok_nxt   = tok_cnt + CNT_W'(1);
                    burst_nxt = burst_inc;
                    wait_nxt  = '0;
                end else begin
                    // Never abort a DATA phase: just flag the stall and keep waiting.
                    wait_nxt = wait_inc;
                    if (wait_inc >= WAIT_W'(TO_CYCLES)) err_nxt = 1'b1;
                end
            end
            NULLW: begin
                if (!steer_comp) begin
                    state_nxt = IDLE;
                    wait_nxt  = '0;
                end else begin
                    wait_nxt = wait_inc;
                    if (wait_inc >= WAIT_W'(TO_CYCLES)) err_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                steer_nxt = SEL_NULL;
                wait_nxt  = '0;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

endmodule
